instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Opposite end of the main control decoder: turns symbolic instruction requests
//  (lw/sw/j plus fields) into 32-bit MIPS words and writes them sequentially into
//  instruction memory. Used as the program loader ahead of the single-cycle core.
//  A small FIFO decouples request acceptance from memory write backpressure.
// PARAMETERS
//  ADDR_W      8   instruction-memory word-address width
//  FIFO_DEPTH  4   encoded-word buffer entries (power of 2, >=2)
//  BASE_ADDR   0   first word address written after reset/start
// PORTS
//  clk         in   1       single clock, rising edge
//  rst_n       in   1       asynchronous, active-low reset
//  start       in   1       restart load: flush FIFO, addr<=BASE_ADDR, clear flags
//  req_valid   in   1       request present
//  req_ready   out  1       request accepted when valid&&ready
//  req_kind    in   2       00 lw, 01 sw, 10 j, 11 reserved
//  req_rs      in   5       base register (lw/sw)
//  req_rt      in   5       data register (lw/sw)
//  req_imm     in   26      [15:0] offset for lw/sw; [25:0] target for j
//  imem_we     out  1       write strobe
//  imem_ready  in   1       memory accepts write when imem_we&&imem_ready
//  imem_addr   out  ADDR_W  write word address
//  imem_wdata  out  32      encoded instruction
//  word_count  out  ADDR_W+1 words written since reset/start
//  mem_full    out  1       last address written; loader halted
//  err         out  1       sticky: reserved kind received
// BEHAVIOUR
//  - Reset (async, rst_n=0): FIFO empty, imem_addr=BASE_ADDR, imem_wdata=0,
//    imem_we=0, req_ready=0 while rst_n low, word_count=0, mem_full=0, err=0, state=IDLE.
//  - Encoding (registered into FIFO on accept):
//    lw {6'b100011,rs,rt,imm[15:0]}; sw {6'b101011,rs,rt,imm[15:0]};
//    j {6'b000010,imm[25:0]}. Reserved: accepted, dropped, err<=1, no write.
//  - req_ready = !fifo_full && !mem_full && !start (registered full; no push on full
//    even if a pop happens that cycle).
//  - imem_we = !fifo_empty && !mem_full; imem_wdata = FIFO head; imem_addr = addr reg.
//    Latency: word accepted at edge N is presented from cycle N+1.
//  - On write handshake: pop, addr+1, word_count+1. If addr was 2^ADDR_W-1:
//    mem_full<=1, addr holds, remaining FIFO words discarded, req_ready=0.
//  - imem_we held with stable addr/wdata while imem_ready=0.
//  - Simultaneous push+pop (not full): both occur, occupancy unchanged.
//  - start (1 cycle, sync): priority over everything; FIFO flushed, addr<=BASE_ADDR,
//    word_count<=0, mem_full<=0, err<=0; request in that cycle not accepted.
//  - FSM: IDLE (FIFO empty) -> RUN (FIFO non-empty) -> IDLE when drained;
//    any -> FULL on last-address write; FULL -> IDLE only on start; any -> IDLE on start.
//  - Reset mid-write aborts immediately; no partial write is retried.
// STRUCTURE
//  - Shared package: OP_LW/OP_SW/OP_J opcode constants and KIND_* codes, same
//    constants used by the main control decoder; FSM state encoding.
//  - One sub-module: sync_fifo (WIDTH=32, DEPTH=FIFO_DEPTH, full/empty flags).
// TESTING
//  1 lw rs=2 rt=5 imm=16'h0010, imem_ready=1 -> cycle+1: we=1, addr=0, wdata=32'h8C450010.
//  2 sw rs=3 rt=4 imm=0x0008 then j imm=26'h0000040 -> wdata 32'hAC640008 at addr0,
//    32'h08000040 at addr1; word_count=2.
//  3 kind=11 -> err=1, no imem_we, word_count unchanged; start clears err.
//  4 imem_ready=0, 6 back-to-back requests -> 4 accepted, req_ready=0, wdata/addr stable;
//    release -> 4 writes in order, then remaining requests accepted.
//  5 ADDR_W=2: 5 requests -> addrs 0..3 written, mem_full=1, 5th never written;
//    start -> addr=0, mem_full=0.
//  6 rst_n low while FIFO holds 3 words -> outputs at reset values, FIFO empty, no write.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared opcode/kind constants, request payload and FSM encoding for the program loader.
package instr_encoder_pkg;
   localparam int unsigned INSTR_W = 32;
   localparam int unsigned KIND_W  = 2;
   localparam int unsigned REG_W   = 5;
   localparam int unsigned IMM_W   = 26;

   localparam logic [5:0] OP_LW = 6'b100011;
   localparam logic [5:0] OP_SW = 6'b101011;
   localparam logic [5:0] OP_J  = 6'b000010;

   localparam logic [KIND_W-1:0] KIND_LW   = 2'b00;
   localparam logic [KIND_W-1:0] KIND_SW   = 2'b01;
   localparam logic [KIND_W-1:0] KIND_J    = 2'b10;
   localparam logic [KIND_W-1:0] KIND_RSVD = 2'b11;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_FULL = 2'd2;

   typedef struct packed {
      logic [KIND_W-1:0] kind;
      logic [REG_W-1:0]  rs;
      logic [REG_W-1:0]  rt;
      logic [IMM_W-1:0]  imm;
   } req_t;

   // Reserved kinds encode to zero; they are never pushed.
   function automatic logic [INSTR_W-1:0] encode(input req_t r);
      case (r.kind)
         KIND_LW: encode = {OP_LW, r.rs, r.rt, r.imm[15:0]};
         KIND_SW: encode = {OP_SW, r.rs, r.rt, r.imm[15:0]};
         KIND_J:  encode = {OP_J, r.imm};
         default: encode = '0;
      endcase
   endfunction
endpackage

// File: rtl/instr_encoder_if.sv
// Symbolic instruction request channel (producer = master, loader = slave).
interface instr_encoder_if;
   import instr_encoder_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic [KIND_W-1:0] req_kind;
   logic [REG_W-1:0]  req_rs;
   logic [REG_W-1:0]  req_rt;
   logic [IMM_W-1:0]  req_imm;

   modport master (output req_valid, req_kind, req_rs, req_rt, req_imm, input req_ready);
   modport slave  (input req_valid, req_kind, req_rs, req_rt, req_imm, output req_ready);
endinterface

// File: rtl/instr_encoder_sync_fifo.sv
// Single-clock FIFO with flush; full/empty derived from registered pointers.
module instr_encoder_sync_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_flush,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_din,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_dout,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);
   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W:0]   r_wptr;
   logic [PTR_W:0]   r_rptr;
   logic             w_push;
   logic             w_pop;

   assign o_count = r_wptr - r_rptr;
   assign o_full  = (o_count == (PTR_W+1)'(DEPTH));
   assign o_empty = (r_wptr == r_rptr);
   assign o_dout  = r_mem[r_rptr[PTR_W-1:0]];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   // Flush wins over any push/pop in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else if (i_flush) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + (PTR_W+1)'(1);
         if (w_pop)  r_rptr <= r_rptr + (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && !i_flush) r_mem[r_wptr[PTR_W-1:0]] <= i_din;
   end
endmodule

// File: rtl/instr_encoder.sv
// Program loader: encodes lw/sw/j requests into MIPS words and writes them
// sequentially into instruction memory through a small decoupling FIFO.
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned BASE_ADDR  = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_start,
   instr_encoder_if.slave     s_req,
   output logic               o_imem_we,
   input  logic               i_imem_ready,
   output logic [ADDR_W-1:0]  o_imem_addr,
   output logic [INSTR_W-1:0] o_imem_wdata,
   output logic [ADDR_W:0]    o_word_count,
   output logic               o_mem_full,
   output logic               o_err
);
   localparam int unsigned     CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

   logic [1:0]         r_state;
   logic [1:0]         w_next;
   logic [ADDR_W-1:0]  r_addr;
   logic [ADDR_W:0]    r_word_count;
   logic               r_err;

   req_t               w_req;
   logic [INSTR_W-1:0] w_enc;
   logic [INSTR_W-1:0] w_head;
   logic [CNT_W-1:0]   w_fifo_count;
   logic               w_fifo_full;
   logic               w_fifo_empty;
   logic               w_full_st;
   logic               w_accept;
   logic               w_rsvd;
   logic               w_push;
   logic               w_we;
   logic               w_wr;
   logic               w_last;
   logic               w_flush;
   logic               w_drain;

   assign w_req     = {s_req.req_kind, s_req.req_rs, s_req.req_rt, s_req.req_imm};
   assign w_enc     = encode(w_req);
   assign w_full_st = (r_state == ST_FULL);

   // Ready uses the registered full flag, so a pop never frees a slot in the same cycle.
   assign s_req.req_ready = rst_n && !w_fifo_full && !w_full_st && !i_start;
   assign w_accept = s_req.req_valid && s_req.req_ready;
   assign w_rsvd   = (w_req.kind == KIND_RSVD);
   assign w_push   = w_accept && !w_rsvd;
   assign w_we     = !w_fifo_empty && !w_full_st;
   assign w_wr     = w_we && i_imem_ready && !i_start;
   assign w_last   = w_wr && (r_addr == '1);
   assign w_flush  = i_start || w_last;
   assign w_drain  = w_wr && !w_push && (w_fifo_count == CNT_W'(1));

   instr_encoder_sync_fifo #(
      .WIDTH (INSTR_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (w_flush),
      .i_push  (w_push),
      .i_din   (w_enc),
      .i_pop   (w_wr),
      .o_dout  (w_head),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_count (w_fifo_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (i_start) begin
         w_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: if (w_push) w_next = ST_RUN;
            ST_RUN: begin
               if (w_last)       w_next = ST_FULL;
               else if (w_drain) w_next = ST_IDLE;
            end
            ST_FULL: w_next = ST_FULL;
            default: w_next = ST_IDLE;
         endcase
      end
   end

   // Address holds on the final slot so it still shows where loading stopped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr       <= BASE;
         r_word_count <= '0;
         r_err        <= 1'b0;
      end else if (i_start) begin
         r_addr       <= BASE;
         r_word_count <= '0;
         r_err        <= 1'b0;
      end else begin
         if (w_wr) begin
            r_word_count <= r_word_count + (ADDR_W+1)'(1);
            if (!w_last) r_addr <= r_addr + ADDR_W'(1);
         end
         if (w_accept && w_rsvd) r_err <= 1'b1;
      end
   end

   assign o_imem_we    = w_we;
   assign o_imem_addr  = r_addr;
   assign o_imem_wdata = w_fifo_empty ? '0 : w_head;
   assign o_word_count = r_word_count;
   assign o_mem_full   = w_full_st;
   assign o_err        = r_err;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder (ADDR_W=8 and ADDR_W=2 instances).
module tb_instr_encoder;
   import instr_encoder_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        a_start, a_ready, a_we, a_full, a_err;
   logic [7:0]  a_addr;
   logic [31:0] a_wdata;
   logic [8:0]  a_cnt;
   logic        b_start, b_ready, b_we, b_full, b_err;
   logic [1:0]  b_addr;
   logic [31:0] b_wdata;
   logic [2:0]  b_cnt;

   instr_encoder_if a_if ();
   instr_encoder_if b_if ();

   instr_encoder #(.ADDR_W(8), .FIFO_DEPTH(4), .BASE_ADDR(0)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .i_start(a_start), .s_req(a_if),
      .o_imem_we(a_we), .i_imem_ready(a_ready), .o_imem_addr(a_addr),
      .o_imem_wdata(a_wdata), .o_word_count(a_cnt), .o_mem_full(a_full), .o_err(a_err));

   instr_encoder #(.ADDR_W(2), .FIFO_DEPTH(4), .BASE_ADDR(0)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .i_start(b_start), .s_req(b_if),
      .o_imem_we(b_we), .i_imem_ready(b_ready), .o_imem_addr(b_addr),
      .o_imem_wdata(b_wdata), .o_word_count(b_cnt), .o_mem_full(b_full), .o_err(b_err));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive_a(input logic v, input logic [1:0] k, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [25:0] imm);
      a_if.req_valid = v; a_if.req_kind = k; a_if.req_rs = rs; a_if.req_rt = rt; a_if.req_imm = imm;
   endtask

   task automatic drive_b(input logic v, input logic [25:0] imm);
      b_if.req_valid = v; b_if.req_kind = KIND_J; b_if.req_rs = '0; b_if.req_rt = '0; b_if.req_imm = imm;
   endtask

   typedef struct {
      logic [1:0]  kind;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [25:0] imm;
      logic [31:0] wdata;
      logic        wr;
   } vec_t;

   vec_t        vecs [7];
   logic [31:0] exp4 [6];
   logic [31:0] exp5 [4];

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_addr, exp_cnt, k, nwr;
      logic acc_now;
      a_start = 0; a_ready = 0; b_start = 0; b_ready = 0;
      drive_a(0, 2'b00, 0, 0, 0);
      drive_b(0, 0);

      vecs[0] = '{KIND_LW,   5'd2,  5'd5,  26'h0000010, 32'h8C450010, 1'b1};
      vecs[1] = '{KIND_SW,   5'd3,  5'd4,  26'h0000008, 32'hAC640008, 1'b1};
      vecs[2] = '{KIND_J,    5'd0,  5'd0,  26'h0000040, 32'h08000040, 1'b1};
      vecs[3] = '{KIND_LW,   5'd31, 5'd31, 26'h3FFFFFF, 32'h8FFFFFFF, 1'b1};
      vecs[4] = '{KIND_SW,   5'd0,  5'd1,  26'h2A5A5A5, 32'hAC01A5A5, 1'b1};
      vecs[5] = '{KIND_J,    5'd7,  5'd9,  26'h3FFFFFF, 32'h0BFFFFFF, 1'b1};
      vecs[6] = '{KIND_RSVD, 5'd1,  5'd1,  26'h0000001, 32'h00000000, 1'b0};
      exp4 = '{32'h8C000000, 32'h8C210001, 32'h8C420002, 32'h8C630003, 32'h8C840004, 32'h8CA50005};
      exp5 = '{32'h08000001, 32'h08000002, 32'h08000003, 32'h08000004};

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_we", a_we, 0);        chk("rst_ready", a_if.req_ready, 0);
      chk("rst_addr", a_addr, 0);    chk("rst_wdata", a_wdata, 0);
      chk("rst_count", a_cnt, 0);    chk("rst_full", a_full, 0);
      chk("rst_err", a_err, 0);      chk("rst_b_we", b_we, 0);
      rst_n = 1'b1;
      a_ready = 1'b1;

      // Table-driven encoding with immediate memory acceptance
      exp_addr = 0; exp_cnt = 0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         chk("vec_count", a_cnt, 64'(exp_cnt));
         drive_a(1, vecs[i].kind, vecs[i].rs, vecs[i].rt, vecs[i].imm);
         #1 chk("vec_ready", a_if.req_ready, 1);
         @(posedge clk); #1 drive_a(0, 2'b00, 0, 0, 0);
         @(negedge clk);
         if (vecs[i].wr) begin
            chk("vec_we", a_we, 1);
            chk("vec_addr", a_addr, 64'(exp_addr));
            chk("vec_wdata", a_wdata, vecs[i].wdata);
            chk("vec_err_clear", a_err, 0);
            exp_addr++; exp_cnt++;
         end else begin
            chk("rsvd_no_we", a_we, 0);
            chk("rsvd_err", a_err, 1);
         end
      end
      @(negedge clk);
      chk("post_count", a_cnt, 6); chk("post_err", a_err, 1); chk("post_addr", a_addr, 6);

      // Start clears state and blocks the concurrent request
      a_start = 1'b1; drive_a(1, KIND_LW, 5'd1, 5'd1, 26'd1);
      #1 chk("start_ready", a_if.req_ready, 0);
      @(posedge clk); #1 a_start = 1'b0; drive_a(0, 2'b00, 0, 0, 0);
      @(negedge clk);
      chk("start_err", a_err, 0);   chk("start_count", a_cnt, 0);
      chk("start_addr", a_addr, 0); chk("start_we", a_we, 0);

      // Backpressure: FIFO fills to 4 while memory stalls
      a_ready = 1'b0; k = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         drive_a(1, KIND_LW, 5'(k), 5'(k), 26'(k));
         #1 acc_now = a_if.req_ready;
         @(posedge clk);
         if (acc_now) k++;
      end
      @(negedge clk);
      chk("bp_accepted", 64'(k), 4); chk("bp_ready", a_if.req_ready, 0);
      chk("bp_we", a_we, 1); chk("bp_addr", a_addr, 0); chk("bp_wdata", a_wdata, exp4[0]);
      repeat (3) @(negedge clk);
      chk("bp_hold_addr", a_addr, 0); chk("bp_hold_wdata", a_wdata, exp4[0]);
      a_ready = 1'b1;
      #1 chk("bp_pop_no_push", a_if.req_ready, 0);
      nwr = 0;
      for (int c = 0; c < 20 && nwr < 6; c++) begin
         if (a_we) begin
            chk("bp_order_wdata", a_wdata, exp4[nwr]);
            chk("bp_order_addr", a_addr, 64'(nwr));
            nwr++;
         end
         acc_now = a_if.req_valid && a_if.req_ready;
         @(posedge clk); #1;
         if (acc_now) begin
            k++;
            if (k < 6) drive_a(1, KIND_LW, 5'(k), 5'(k), 26'(k));
            else       drive_a(0, 2'b00, 0, 0, 0);
         end
         @(negedge clk); #1;
      end
      chk("bp_writes", 64'(nwr), 6); chk("bp_all_acc", 64'(k), 6); chk("bp_count", a_cnt, 6);

      // Reset while FIFO holds 3 words
      a_ready = 1'b0;
      for (int j = 0; j < 3; j++) begin
         drive_a(1, KIND_SW, 5'(j), 5'(j), 26'(j));
         @(posedge clk); #1;
      end
      drive_a(0, 2'b00, 0, 0, 0);
      @(negedge clk);
      chk("pre_rst_we", a_we, 1); chk("pre_rst_addr", a_addr, 6);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_we", a_we, 0);      chk("mid_rst_wdata", a_wdata, 0);
      chk("mid_rst_addr", a_addr, 0);  chk("mid_rst_ready", a_if.req_ready, 0);
      chk("mid_rst_count", a_cnt, 0);
      @(negedge clk); rst_n = 1'b1; a_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_we", a_we, 0); chk("post_rst_count", a_cnt, 0);

      // ADDR_W=2: last address halts the loader
      b_ready = 1'b1; k = 0; nwr = 0;
      drive_b(1, 26'(k + 1));
      #1;
      for (int c = 0; c < 15; c++) begin
         if (b_we) begin
            if (nwr < 4) begin
               chk("full_wdata", b_wdata, exp5[nwr]);
               chk("full_addr", b_addr, 64'(nwr));
            end else begin
               chk("full_extra_write", b_we, 0);
            end
            nwr++;
         end
         acc_now = b_if.req_valid && b_if.req_ready;
         @(posedge clk); #1;
         if (acc_now) begin
            k++;
            if (k < 5) drive_b(1, 26'(k + 1));
            else       drive_b(0, 0);
         end
         @(negedge clk); #1;
      end
      drive_b(0, 0);
      chk("full_writes", 64'(nwr), 4); chk("full_flag", b_full, 1);
      chk("full_we", b_we, 0);          chk("full_ready", b_if.req_ready, 0);
      chk("full_addr_hold", b_addr, 3); chk("full_count", b_cnt, 4);
      b_start = 1'b1;
      @(posedge clk); #1 b_start = 1'b0;
      @(negedge clk);
      chk("restart_addr", b_addr, 0); chk("restart_full", b_full, 0);
      chk("restart_count", b_cnt, 0); chk("restart_ready", b_if.req_ready, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
